// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one uart_tx serializer among N_SRC
// byte sources. A grant is held until the source marks its last byte, the
// burst limit is reached, or the source stays silent for HOLD_TIMEOUT cycles.
module uart_tx_arbiter #(
    parameter int unsigned N_SRC        = 4,
    parameter int unsigned IDW          = 2,
    parameter int unsigned MAX_BURST    = 16,
    parameter int unsigned HOLD_TIMEOUT = 8680,
    parameter int unsigned BUSY_WAIT    = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_SRC-1:0]     src_valid,
    input  logic [8*N_SRC-1:0]   src_data,
    input  logic [N_SRC-1:0]     src_last,
    output logic [N_SRC-1:0]     src_ready,
    output logic                 tx_start,
    output logic [7:0]           tx_data,
    input  logic                 tx_busy,
    output logic                 grant_valid,
    output logic [IDW-1:0]       grant_id,
    output logic                 hold_abort,
    output logic                 err_busy_to
);

    localparam int unsigned BCW = (MAX_BURST > 0)    ? $clog2(MAX_BURST + 1)    : 1;
    localparam int unsigned HCW = (HOLD_TIMEOUT > 0) ? $clog2(HOLD_TIMEOUT + 1) : 1;
    localparam int unsigned WCW = (BUSY_WAIT > 0)    ? $clog2(BUSY_WAIT + 1)    : 1;

    localparam logic [BCW-1:0] BURST_SAT = BCW'((MAX_BURST == 0) ? 1 : MAX_BURST);
    localparam logic [HCW-1:0] HOLD_LAST = HCW'((HOLD_TIMEOUT == 0) ? 0 : HOLD_TIMEOUT - 1);
    localparam logic [WCW-1:0] WAIT_MAX  = WCW'(BUSY_WAIT);
    localparam logic [IDW-1:0] LAST_ID   = IDW'(N_SRC - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_START,
        S_WAIT_BUSY,
        S_WAIT_IDLE,
        S_HOLD
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [IDW-1:0]   r_grant_id;
    logic             r_grant_valid;
    logic [IDW-1:0]   r_rr_ptr;
    logic [7:0]       r_tx_data;
    logic             r_last_q;
    logic [BCW-1:0]   r_burst_cnt;
    logic [HCW-1:0]   r_hold_cnt;
    logic [WCW-1:0]   r_wait_cnt;

    logic [2*N_SRC-1:0] w_dbl;
    logic [N_SRC-1:0]   w_rot;
    logic               w_pick_found;
    logic [IDW-1:0]     w_pick_id;
    logic               w_sel_valid;
    logic [7:0]         w_sel_data;
    logic               w_sel_last;
    logic               w_burst_full;
    logic               w_busy_to;
    logic               w_hold_to;
    logic               w_release;

    // Round-robin pick: rotate valids so rr_ptr sits at bit 0, take the lowest set bit
    always_comb begin
        logic [IDW:0] sum;
        w_dbl        = {src_valid, src_valid};
        w_rot        = N_SRC'(w_dbl >> r_rr_ptr);
        w_pick_found = 1'b0;
        w_pick_id    = '0;
        sum          = '0;
        for (int unsigned k = 0; k < N_SRC; k++) begin
            if (!w_pick_found && w_rot[k]) begin
                w_pick_found = 1'b1;
                sum = {1'b0, r_rr_ptr} + (IDW+1)'(k);
                if (sum >= (IDW+1)'(N_SRC)) begin
                    sum = sum - (IDW+1)'(N_SRC);
                end
                w_pick_id = sum[IDW-1:0];
            end
        end
    end

    // Mux the granted source's valid/data/last
    always_comb begin
        w_sel_valid = 1'b0;
        w_sel_data  = '0;
        w_sel_last  = 1'b0;
        for (int unsigned k = 0; k < N_SRC; k++) begin
            if (IDW'(k) == r_grant_id) begin
                w_sel_valid = src_valid[k];
                w_sel_data  = src_data[8*k +: 8];
                w_sel_last  = src_last[k];
            end
        end
    end

    // Release and timeout conditions shared by next-state, outputs and datapath
    always_comb begin
        w_burst_full = (MAX_BURST != 0) && (r_burst_cnt == BURST_SAT);
        w_busy_to    = (r_state == S_WAIT_BUSY) && !tx_busy && (r_wait_cnt == WAIT_MAX);
        w_hold_to    = (r_state == S_HOLD) && !w_sel_valid && (r_hold_cnt == HOLD_LAST);
        w_release    = ((r_state == S_WAIT_IDLE) && !tx_busy && (r_last_q || w_burst_full))
                       || w_hold_to;
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:      if (w_pick_found) w_next = S_ISSUE;
            S_ISSUE:     w_next = S_START;
            S_START:     w_next = S_WAIT_BUSY;
            S_WAIT_BUSY: if (tx_busy || w_busy_to) w_next = S_WAIT_IDLE;
            S_WAIT_IDLE: begin
                if (!tx_busy) begin
                    if (w_release)        w_next = S_IDLE;
                    else if (w_sel_valid) w_next = S_ISSUE;
                    else                  w_next = S_HOLD;
                end
            end
            S_HOLD: begin
                if (w_sel_valid)    w_next = S_ISSUE;
                else if (w_hold_to) w_next = S_IDLE;
            end
            default:     w_next = S_IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        src_ready = '0;
        if (r_state == S_ISSUE) begin
            for (int unsigned k = 0; k < N_SRC; k++) begin
                src_ready[k] = (IDW'(k) == r_grant_id);
            end
        end
        tx_start    = (r_state == S_START);
        hold_abort  = w_hold_to;
        err_busy_to = w_busy_to;
        grant_valid = r_grant_valid;
        grant_id    = r_grant_id;
        tx_data     = r_tx_data;
    end

    // Grant, captured byte, round-robin pointer and saturating counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_grant_id    <= '0;
            r_grant_valid <= 1'b0;
            r_rr_ptr      <= '0;
            r_tx_data     <= '0;
            r_last_q      <= 1'b0;
            r_burst_cnt   <= '0;
            r_hold_cnt    <= '0;
            r_wait_cnt    <= '0;
        end else begin
            if ((r_state == S_IDLE) && w_pick_found) begin
                r_grant_id    <= w_pick_id;
                r_grant_valid <= 1'b1;
                r_burst_cnt   <= '0;
            end
            if (r_state == S_ISSUE) begin
                r_tx_data <= w_sel_data;
                r_last_q  <= w_sel_last;
                if (r_burst_cnt != BURST_SAT) begin
                    r_burst_cnt <= r_burst_cnt + 1'b1;
                end
            end
            if (w_release) begin
                r_grant_valid <= 1'b0;
                r_rr_ptr      <= (r_grant_id == LAST_ID) ? '0 : r_grant_id + 1'b1;
            end
            if (r_state == S_WAIT_BUSY) begin
                if (r_wait_cnt != WAIT_MAX) r_wait_cnt <= r_wait_cnt + 1'b1;
            end else begin
                r_wait_cnt <= '0;
            end
            if (r_state == S_HOLD) begin
                if (r_hold_cnt != HOLD_LAST) r_hold_cnt <= r_hold_cnt + 1'b1;
            end else begin
                r_hold_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: per-source byte queues, a uart_tx busy
// model, and a scoreboard of expected (grant_id, byte) frames in send order.
module tb_uart_tx_arbiter;

    localparam int N        = 4;
    localparam int IDW      = 2;
    localparam int MB       = 16;
    localparam int HT       = 40;
    localparam int BW       = 8;
    localparam int BUSY_LEN = 30;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [N-1:0]     src_valid = '0;
    logic [8*N-1:0]   src_data  = '0;
    logic [N-1:0]     src_last  = '0;
    logic [N-1:0]     src_ready;
    logic             tx_start;
    logic [7:0]       tx_data;
    logic             tx_busy = 1'b0;
    logic             grant_valid;
    logic [IDW-1:0]   grant_id;
    logic             hold_abort;
    logic             err_busy_to;

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .N_SRC(N), .IDW(IDW), .MAX_BURST(MB), .HOLD_TIMEOUT(HT), .BUSY_WAIT(BW)
    ) dut (
        .clk(clk), .rst(rst),
        .src_valid(src_valid), .src_data(src_data), .src_last(src_last),
        .src_ready(src_ready),
        .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy),
        .grant_valid(grant_valid), .grant_id(grant_id),
        .hold_abort(hold_abort), .err_busy_to(err_busy_to)
    );

    int checks   = 0;
    int failures = 0;

    logic [8:0]     src_q [N][$];
    logic [IDW+7:0] exp_q [$];

    int   cyc = 0;
    bit   bfm_en = 1'b1;
    int   bfm_cnt = 0;
    logic [N-1:0] prev_valid = '0;
    logic prev_busy = 1'b0;
    int   rise_cyc [N];
    int   ready_cyc [N];
    int   ready_cnt [N];
    int   start_cyc = 0, fall_cyc = 0, abort_cyc = 0, err_cyc = 0;
    int   n_abort = 0, n_err = 0, n_start = 0;
    logic gv_at_abort = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One clock: monitor/scoreboard at negedge, then busy model and source drivers after posedge
    task automatic tick();
        logic [N-1:0]   acc;
        logic [N-1:0]   oh;
        logic           start_now;
        logic [IDW+7:0] e;
        @(negedge clk);
        acc       = src_valid & src_ready;
        start_now = tx_start;
        for (int i = 0; i < N; i++) begin
            if (src_valid[i] && !prev_valid[i]) rise_cyc[i] = cyc;
            if (src_ready[i]) begin
                ready_cyc[i] = cyc;
                ready_cnt[i]++;
            end
        end
        prev_valid = src_valid;
        if (src_ready != '0) begin
            oh = '0;
            oh[grant_id] = 1'b1;
            chk("ready_owner", 32'(src_ready), 32'(oh));
            chk("ready_grant_valid", 32'(grant_valid), 1);
        end
        if (tx_start) begin
            start_cyc = cyc;
            n_start++;
            chk("start_while_busy", 32'(tx_busy), 0);
            chk("sb_nonempty", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("sb_frame", 32'({grant_id, tx_data}), 32'(e));
            end
        end
        if (prev_busy && !tx_busy) fall_cyc = cyc;
        prev_busy = tx_busy;
        if (hold_abort) begin
            abort_cyc   = cyc;
            n_abort++;
            gv_at_abort = grant_valid;
        end
        if (err_busy_to) begin
            err_cyc = cyc;
            n_err++;
        end
        @(posedge clk);
        cyc++;
        #1;
        if (start_now && bfm_en) bfm_cnt = BUSY_LEN;
        else if (bfm_cnt > 0)    bfm_cnt--;
        tx_busy = (bfm_cnt != 0);
        for (int i = 0; i < N; i++) begin
            if (acc[i] && src_q[i].size() != 0) void'(src_q[i].pop_front());
            if (src_q[i].size() != 0) begin
                src_valid[i]       = 1'b1;
                src_data[8*i +: 8] = src_q[i][0][7:0];
                src_last[i]        = src_q[i][0][8];
            end else begin
                src_valid[i]       = 1'b0;
                src_data[8*i +: 8] = '0;
                src_last[i]        = 1'b0;
            end
        end
    endtask

    task automatic push(input int s, input logic last, input logic [7:0] d);
        src_q[s].push_back({last, d});
    endtask

    task automatic expect_frame(input int s, input logic [7:0] d);
        exp_q.push_back({IDW'(s), d});
    endtask

    task automatic wait_done(input string tag, input int bound);
        bit done = 1'b0;
        for (int i = 0; i < bound && !done; i++) begin
            tick();
            done = (exp_q.size() == 0) && (src_valid == '0) && !grant_valid && !tx_busy;
        end
        chk({"done_", tag}, 32'(done), 1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            rise_cyc[i] = 0; ready_cyc[i] = 0; ready_cnt[i] = 0;
        end

        // Reset state
        tick(); tick(); tick();
        chk("reset_outputs",
            32'({src_ready, tx_start, tx_data, grant_valid, grant_id, hold_abort, err_busy_to}), 0);
        rst = 1'b0;
        tick(); tick();

        // Test 1: single byte from src0, latency and single-cycle ready
        for (int i = 0; i < N; i++) ready_cnt[i] = 0;
        push(0, 1'b1, 8'h41);
        expect_frame(0, 8'h41);
        wait_done("t1", 500);
        chk("t1_ready_lat", 32'(ready_cyc[0] - rise_cyc[0]), 1);
        chk("t1_start_lat", 32'(start_cyc - rise_cyc[0]), 2);
        chk("t1_ready_cnt", 32'(ready_cnt[0]), 1);

        // rr_ptr is now 1: src1 wins over src0
        push(0, 1'b1, 8'hC0);
        push(1, 1'b1, 8'hC1);
        expect_frame(1, 8'hC1);
        expect_frame(0, 8'hC0);
        wait_done("t1_rr", 500);

        // Test 2a: all four valid from rr_ptr 0
        do_reset();
        for (int i = 0; i < N; i++) push(i, 1'b1, 8'hA0 + 8'(i));
        for (int i = 0; i < N; i++) expect_frame(i, 8'hA0 + 8'(i));
        wait_done("t2a", 1000);

        // Move rr_ptr to 2, then all four again
        push(1, 1'b1, 8'hB1);
        expect_frame(1, 8'hB1);
        wait_done("t2_prep", 500);
        for (int i = 0; i < N; i++) push(i, 1'b1, 8'hA0 + 8'(i));
        expect_frame(2, 8'hA2);
        expect_frame(3, 8'hA3);
        expect_frame(0, 8'hA0);
        expect_frame(1, 8'hA1);
        wait_done("t2b", 1000);

        // Test 3: multi-byte message from src1 holds the grant while src0 waits
        push(0, 1'b1, 8'h5A);
        expect_frame(0, 8'h5A);
        wait_done("t3_prep", 500);
        push(1, 1'b0, 8'h10);
        push(1, 1'b0, 8'h11);
        push(1, 1'b1, 8'h12);
        push(0, 1'b1, 8'h20);
        expect_frame(1, 8'h10);
        expect_frame(1, 8'h11);
        expect_frame(1, 8'h12);
        expect_frame(0, 8'h20);
        wait_done("t3", 1000);

        // Test 4: 20 unterminated bytes from src3 hit MAX_BURST, src2 slips in between
        push(2, 1'b1, 8'h5B);
        expect_frame(2, 8'h5B);
        wait_done("t4_prep", 500);
        n_abort = 0;
        for (int i = 0; i < 20; i++) push(3, 1'b0, 8'h60 + 8'(i));
        push(2, 1'b1, 8'h99);
        for (int i = 0; i < MB; i++) expect_frame(3, 8'h60 + 8'(i));
        expect_frame(2, 8'h99);
        for (int i = MB; i < 20; i++) expect_frame(3, 8'h60 + 8'(i));
        wait_done("t4", 3000);
        chk("t4_aborts", 32'(n_abort), 1);

        // Test 5: open message goes silent -> hold timeout
        n_abort = 0;
        push(2, 1'b0, 8'h55);
        expect_frame(2, 8'h55);
        for (int i = 0; i < 500 && n_abort == 0; i++) tick();
        chk("t5_abort_seen", 32'(n_abort), 1);
        chk("t5_abort_lat", 32'(abort_cyc - fall_cyc), HT);
        chk("t5_gv_at_abort", 32'(gv_at_abort), 1);
        tick();
        chk("t5_gv_after", 32'(grant_valid), 0);

        // Test 6: serializer never reports busy
        bfm_en = 1'b0;
        n_err  = 0;
        push(1, 1'b1, 8'h77);
        expect_frame(1, 8'h77);
        for (int i = 0; i < 200 && n_err == 0; i++) tick();
        chk("t6_err_lat", 32'(err_cyc - start_cyc), BW + 1);
        wait_done("t6_err", 500);
        bfm_en = 1'b1;
        push(0, 1'b1, 8'h78);
        expect_frame(0, 8'h78);
        wait_done("t6_continue", 500);
        chk("t6_err_count", 32'(n_err), 1);

        // Reset in the middle of a frame
        n_start = 0;
        push(3, 1'b1, 8'h3C);
        expect_frame(3, 8'h3C);
        for (int i = 0; i < 100 && n_start == 0; i++) tick();
        for (int i = 0; i < 5; i++) tick();
        chk("t6_gv_pre_reset", 32'(grant_valid), 1);
        rst = 1'b1;
        #1;
        chk("reset_mid_outputs",
            32'({src_ready, tx_start, tx_data, grant_valid, grant_id, hold_abort, err_busy_to}), 0);
        chk("sb_drained", 32'(exp_q.size()), 0);
        bfm_cnt = 0;
        tx_busy = 1'b0;
        tick(); tick(); tick();
        rst = 1'b0;
        tick(); tick(); tick();
        chk("post_reset_idle",
            32'({src_ready, tx_start, grant_valid, hold_abort, err_busy_to}), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
